// File: rtl/ifmap_packer_if.sv
// ifmap_packer_if: bundles the frame-control, serial pixel and packed buffer
// write signals of the IFMap packer.
//   master : pixel source / buffer side (drives start, row_len, num_rows,
//            pix_in, pix_valid, buf_full; observes the packer outputs)
//   slave  : the packer itself
interface ifmap_packer_if #(
    parameter int DATA_WIDTH   = 16,
    parameter int PAR_WRITE    = 7,
    parameter int ROW_LEN_SIZE = 8
);
    localparam int CNT_W = $clog2(PAR_WRITE + 1);

    logic                                 start;
    logic [ROW_LEN_SIZE-1:0]              row_len;
    logic [ROW_LEN_SIZE-1:0]              num_rows;
    logic [DATA_WIDTH-1:0]                pix_in;
    logic                                 pix_valid;
    logic                                 pix_ready;
    logic                                 buf_full;
    logic [(DATA_WIDTH+2)*PAR_WRITE-1:0]  IFMap_out;
    logic                                 wen_IFMap_buffer;
    logic [CNT_W-1:0]                     wr_count;
    logic                                 done;

    modport master (
        output start, row_len, num_rows, pix_in, pix_valid, buf_full,
        input  pix_ready, IFMap_out, wen_IFMap_buffer, wr_count, done
    );

    modport slave (
        input  start, row_len, num_rows, pix_in, pix_valid, buf_full,
        output pix_ready, IFMap_out, wen_IFMap_buffer, wr_count, done
    );
endinterface

// File: rtl/ifmap_packer.sv
// ifmap_packer: collects a serial pixel stream into PAR_WRITE-wide buffer
// writes, tagging every pixel with row-start / row-end flags.
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-low reset
//   bus   - ifmap_packer_if.slave: start/row_len/num_rows frame control,
//           pix_in/pix_valid/pix_ready pixel stream, buf_full back-pressure,
//           IFMap_out/wen_IFMap_buffer/wr_count buffer write, done pulse.
// Slot 0 sits in the MSBs of IFMap_out; each slot is {flag[1:0], pixel}.
module ifmap_packer #(
    parameter int DATA_WIDTH   = 16,
    parameter int PAR_WRITE    = 7,
    parameter int ROW_LEN_SIZE = 8
) (
    input  logic        clk,
    input  logic        rst,
    ifmap_packer_if.slave bus
);
    localparam int SW    = DATA_WIDTH + 2;
    localparam int CNT_W = $clog2(PAR_WRITE + 1);

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

    state_t                          state_q;
    logic [ROW_LEN_SIZE-1:0]         len_q, rows_q, col_q, row_q;
    logic [CNT_W-1:0]                slot_q;
    logic [0:PAR_WRITE-1][SW-1:0]    slots_q;     // index 0 lands in the MSBs
    logic                            frame_end_q; // final pixel already packed
    logic                            pix_ready_q;
    logic                            done_q;

    logic       accept;
    logic       col_last, pix_last, slot_last;
    logic [1:0] flag_d;

    assign accept    = pix_ready_q & bus.pix_valid;
    assign col_last  = (col_q == len_q - ROW_LEN_SIZE'(1));
    assign pix_last  = col_last & (row_q == rows_q - ROW_LEN_SIZE'(1));
    assign slot_last = (slot_q == CNT_W'(PAR_WRITE - 1));
    // row_len=1 makes both conditions true, giving 2'b11
    assign flag_d    = {col_q == '0, col_last};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            rows_q      <= '0;
            col_q       <= '0;
            row_q       <= '0;
            slot_q      <= '0;
            slots_q     <= '0;
            frame_end_q <= 1'b0;
            pix_ready_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.row_len != '0 && bus.num_rows != '0) begin
                            len_q       <= bus.row_len;
                            rows_q      <= bus.num_rows;
                            col_q       <= '0;
                            row_q       <= '0;
                            slot_q      <= '0;
                            slots_q     <= '0;
                            frame_end_q <= 1'b0;
                            pix_ready_q <= 1'b1;
                            state_q     <= COLLECT;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        for (int i = 0; i < PAR_WRITE; i++) begin
                            if (slot_q == CNT_W'(i)) slots_q[i] <= {flag_d, bus.pix_in};
                        end
                        slot_q <= slot_q + CNT_W'(1);
                        if (col_last) begin
                            col_q <= '0;
                            row_q <= row_q + ROW_LEN_SIZE'(1);
                        end else begin
                            col_q <= col_q + ROW_LEN_SIZE'(1);
                        end
                        if (pix_last) frame_end_q <= 1'b1;
                        // rows pack across writes; only a full word or the
                        // frame's last pixel triggers a write
                        if (slot_last || pix_last) begin
                            pix_ready_q <= 1'b0;
                            state_q     <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    // buf_full holds everything; the write strobe is combinational
                    if (!bus.buf_full) begin
                        slots_q <= '0;
                        slot_q  <= '0;
                        if (frame_end_q) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            pix_ready_q <= 1'b1;
                            state_q     <= COLLECT;
                        end
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.pix_ready        = pix_ready_q;
    assign bus.IFMap_out        = slots_q;
    assign bus.wr_count         = slot_q;
    assign bus.done             = done_q;
    assign bus.wen_IFMap_buffer = (state_q == WRITE) & ~bus.buf_full;
endmodule

// File: doc/ifmap_packer.md
IFMAP_PACKER -- requirements
Module: ifmap_packer

Interface
REQ-001 Parameter DATA_WIDTH, default 16: pixel width in bits.
REQ-002 Parameter PAR_WRITE, default 7: slots per buffer write.
REQ-003 Parameter ROW_LEN_SIZE, default 8: width of the row_len and num_rows fields.
REQ-004 Port clk, input, 1: single clock; all logic rising-edge.
REQ-005 Port rst, input, 1: reset, asynchronous, active-low.
REQ-006 Port start, input, 1: begin a frame; sampled only in IDLE.
REQ-007 Port row_len, input, ROW_LEN_SIZE: pixels per row; latched on accepted start.
REQ-008 Port num_rows, input, ROW_LEN_SIZE: rows per frame; latched on accepted start.
REQ-009 Port pix_in, input, DATA_WIDTH: serial pixel data.
REQ-010 Port pix_valid, input, 1: pix_in is valid.
REQ-011 Port pix_ready, output, 1: packer accepts a pixel this cycle.
REQ-012 Port buf_full, input, 1: IFMap buffer cannot take a write.
REQ-013 Port IFMap_out, output, (DATA_WIDTH+2)*PAR_WRITE: packed slots; slot 0 occupies the MSBs; each slot is {flag[1:0], pixel}.
REQ-014 Port wen_IFMap_buffer, output, 1: IFMap_out write strobe.
REQ-015 Port wr_count, output, $clog2(PAR_WRITE+1): number of valid slots in the current write.
REQ-016 Port done, output, 1: one-cycle frame-complete pulse.

Function
REQ-017 FSM states: IDLE, COLLECT, WRITE, DONE.
REQ-018 IDLE, start=1, row_len!=0 and num_rows!=0 -> latch both fields, clear the pixel, row and slot counters, go to COLLECT.
REQ-019 IDLE, start=1 with row_len=0 or num_rows=0 -> go to DONE; no write occurs.
REQ-020 pix_ready=1 only in COLLECT; a pixel is accepted when pix_valid and pix_ready are both 1.
REQ-021 Accepted pixel -> stored in the current slot; slot counter increments.
REQ-022 Slot flag rules:
- 2'b10 on the first pixel of a row.
- 2'b01 on the last pixel of a row.
- 2'b11 when row_len=1.
- 2'b00 otherwise.
REQ-023 Column counter wraps to 0 after row_len-1; row counter increments on that wrap.
REQ-024 COLLECT -> WRITE on the cycle after acceptance, when the slot counter reaches PAR_WRITE or the final pixel of the frame is accepted.
- Rows pack contiguously across writes; row boundaries do not force a write.
REQ-025 WRITE with buf_full=0:
- wen_IFMap_buffer=1 for exactly that cycle (Mealy), with IFMap_out and wr_count stable.
- Next cycle: slots and slot counter clear.
- Next state is DONE if the frame is complete, else COLLECT.
REQ-026 WRITE with buf_full=1 -> hold state, data and wr_count; wen_IFMap_buffer=0; pix_ready=0.
REQ-027 Unused slots in a partial final write SHALL be all-zero, including flags; wr_count gives the valid count.
REQ-028 DONE -> done=1 for one cycle, then go to IDLE; start is ignored in DONE.
REQ-029 start asserted outside IDLE SHALL be ignored; the latched row_len and num_rows SHALL not change mid-frame.
REQ-030 Throughput: one pixel per cycle in COLLECT; each write costs at least one extra cycle.
REQ-031 wen_IFMap_buffer SHALL never be asserted while buf_full=1.

Reset
REQ-032 rst=0 (asynchronous) -> IDLE.
- All counters and slots clear.
- IFMap_out=0, wr_count=0, wen_IFMap_buffer=0, pix_ready=0, done=0.
REQ-033 Reset mid-frame SHALL discard partial slots without any write; after release the block waits in IDLE for start.

Verification
REQ-034 row_len=3, num_rows=2, PAR_WRITE=7, pixels 1..6 streamed, buf_full=0 -> one write, wr_count=6.
- Slots: {10,1},{00,2},{01,3},{10,4},{00,5},{01,6}, then slot 6 = 0.
- done pulses 1 cycle after the write.
REQ-035 row_len=7, num_rows=1, pixels 1..7 -> one write, wr_count=7, flags 10,00,00,00,00,00,01.
REQ-036 row_len=4, num_rows=3, 12 pixels -> writes with wr_count 7 then 5.
- Flags in write 1: 10,00,00,01,10,00,00.
- Flags in write 2: 01,10,00,00,01.
REQ-037 row_len=1, num_rows=2, pixels 9,8 -> single write, wr_count=2, slots {11,9},{11,8}.
REQ-038 buf_full=1 held 5 cycles while in WRITE -> wen stays 0, IFMap_out stable, pix_ready=0; write occurs in the first cycle buf_full=0.
REQ-039 rst asserted after 3 of 6 pixels, then a new frame -> no stale-slot write; the new frame's first write carries only new pixels; row_len=0 -> done pulse, no wen.
